spi_xfer_arbiter: RTL and testbench
===================================

Name: spi_xfer_arbiter

Overview:
- Shares the single SPI master/slave datapath (M_S_Integration) among NUM_REQ client requesters.
- Arbitrates round-robin and drives the datapath's slave select, load, send and receive controls through one complete 8-bit exchange per grant.
- Captures the byte the master received and returns it to the granted requester with a one-cycle done pulse.

Parameters:
- NUM_REQ, 3: number of requesters, 1..4.
- XFER_BITS, 8: shift cycles per exchange; must equal the datapath byte width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  NUM_REQ  per-requester transfer request; level, held until done.
- req_slave  input  2*NUM_REQ  target slave per requester; slice i = [2i+1:2i]; legal values 01/10/11.
- req_data  input  8*NUM_REQ  byte to send per requester; slice i = [8i+7:8i].
- grant  output  NUM_REQ  one-hot owner of the current transaction.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- err  output  1  one-cycle pulse, coincident with done, on an illegal slave select.
- rsp_data  output  8  byte received by the master; valid from the done cycle until the next done.
- busy  output  1  high in any state other than IDLE.
- slave_selection  output  2  to datapath.
- loadM, loadS  output  1  to datapath.
- sendM, recieveM  output  1  to datapath.
- Master_Data  output  8  to datapath; the latched requester byte.
- M_recieved_Data  input  8  from datapath.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All outputs 0, including slave_selection=00 and rsp_data=0x00.
  - Round-robin pointer resets so requester 0 has top priority.
  - Reset mid-transaction aborts immediately; no done is issued.
- IDLE:
  - If any req is high, choose the first requester at or after ptr, in circular order.
  - Latch that requester's req_slave and req_data and set grant one-hot.
  - Advance ptr to winner+1, mod NUM_REQ.
  - If the latched slave is 00, go to ERR. Otherwise go to LOAD.
- LOAD, 1 cycle:
  - loadM=loadS=1.
  - slave_selection and Master_Data driven from the latches.
- GAP, 1 cycle:
  - loadM=loadS=0, sendM=recieveM=0.
  - Gives the datapath a settle cycle before shifting.
- SHIFT, XFER_BITS cycles:
  - sendM=recieveM=1.
  - Counter runs 0..XFER_BITS-1; leave on the last count.
- DONE, 1 cycle:
  - sendM=recieveM=0.
  - rsp_data <= M_recieved_Data.
  - done[owner]=1; grant clears at the end of the cycle.
  - Return to IDLE.
- ERR, 1 cycle:
  - No datapath activity: loads and sends stay 0, slave_selection stays 00.
  - done[owner]=1 and err=1; rsp_data unchanged.
  - Return to IDLE.
- Datapath hold rule: slave_selection and Master_Data hold steady from LOAD through DONE. They return to 00 / 0x00 in IDLE.
- Latency: req sampled in IDLE cycle T gives LOAD at T+1, GAP at T+2, SHIFT at T+3..T+10, and DONE at T+11 (XFER_BITS=8).
- Back-to-back: the earliest next LOAD is 2 cycles after DONE (DONE -> IDLE -> LOAD).
- Request changes while a transaction is in flight:
  - Changes to req, req_slave or req_data are ignored.
  - Dropping req mid-transfer does not abort it; done still pulses.
- Simultaneous requests are resolved by ptr only; no requester waits more than NUM_REQ-1 transactions.
- done, err and grant are never high for a non-owner. At most one done bit is high at a time.

Test Plan:
- Single transfer: req[0]=1, slave 01, req_data=0xF0, datapath slave1 preloaded 0xAA.
  -> loadM high exactly 1 cycle, sendM high exactly 8 cycles.
  -> done[0] at T+11, rsp_data=0xAA, slave1 holds 0xF0.
- Round-robin: req=3'b111 held, slaves 01/10/11, data 0x81/0x81/0xFF; slaves hold 0x83/0x83/0xCC.
  -> grants in order 0,1,2,0.
  -> rsp_data 0x83, 0x83, 0xCC on successive done pulses.
- Illegal target: req[1]=1 with slave 00.
  -> done[1] and err at T+1.
  -> no loadM/sendM activity, rsp_data unchanged.
- Request drop: req[2] deasserted during SHIFT.
  -> transfer completes, done[2] still pulses, next arbitration starts from ptr=0.
- Reset mid-SHIFT: rst=0 at shift count 4.
  -> all outputs 0 immediately, no done.
  -> after release, req[1] alone is granted and completes normally.
- Hold check: during each transfer, slave_selection and Master_Data are constant from LOAD to DONE, and busy is high from LOAD to DONE.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master/slave datapath among NUM_REQ clients,
// sequencing load, settle, shift and completion for one byte exchange per grant.
module spi_xfer_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned XFER_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_slave,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rsp_data,
  output logic                   busy,
  output logic [1:0]             slave_selection,
  output logic                   loadM,
  output logic                   loadS,
  output logic                   sendM,
  output logic                   recieveM,
  output logic [7:0]             Master_Data,
  input  logic [7:0]             M_recieved_Data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (XFER_BITS > 1) ? $clog2(XFER_BITS) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StGap   = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;
  localparam logic [2:0] StErr   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         slave_q, slave_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         rsp_q, rsp_d;

  logic               found;
  logic [PtrW-1:0]    win, cand, win_nxt;
  logic [1:0]         win_slave;

  // First requester at or after ptr, searching circularly.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_nxt   = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign win_slave = req_slave[2*win +: 2];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    slave_d = slave_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          slave_d      = win_slave;
          data_d       = req_data[8*win +: 8];
          ptr_d        = win_nxt;
          state_d      = (win_slave == 2'b00) ? StErr : StLoad;
        end
      end
      StLoad: state_d = StGap;
      StGap: begin
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q == CntW'(XFER_BITS - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        rsp_d   = M_recieved_Data;
        grant_d = '0;
        state_d = StIdle;
      end
      StErr: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      slave_q <= 2'b00;
      data_q  <= 8'h00;
      rsp_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      slave_q <= slave_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
    end
  end

  logic dp_active;
  assign dp_active = (state_q == StLoad) || (state_q == StGap) ||
                     (state_q == StShift) || (state_q == StDone);

  assign grant           = grant_q;
  assign busy            = (state_q != StIdle);
  assign loadM           = (state_q == StLoad);
  assign loadS           = (state_q == StLoad);
  assign sendM           = (state_q == StShift);
  assign recieveM        = (state_q == StShift);
  assign slave_selection = dp_active ? slave_q : 2'b00;
  assign Master_Data     = dp_active ? data_q : 8'h00;
  assign done            = ((state_q == StDone) || (state_q == StErr)) ? grant_q : '0;
  assign err             = (state_q == StErr);
  // Received byte is visible in the done cycle itself, then held until the next done.
  assign rsp_data        = (state_q == StDone) ? M_recieved_Data : rsp_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: a swap-style SPI datapath stand-in plus a transaction-level
// model that predicts every output from the cycle offset since each arbitration decision.
module tb_spi_xfer_arbiter;
  localparam int XB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [5:0]  req_slave;
  logic [23:0] req_data;
  logic [2:0]  grant, done;
  logic        err, busy, loadM, loadS, sendM, recieveM;
  logic [7:0]  rsp_data, Master_Data, M_recieved_Data;
  logic [1:0]  slave_selection;

  spi_xfer_arbiter #(.NUM_REQ(3), .XFER_BITS(XB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_slave(req_slave), .req_data(req_data),
    .grant(grant), .done(done), .err(err), .rsp_data(rsp_data), .busy(busy),
    .slave_selection(slave_selection), .loadM(loadM), .loadS(loadS), .sendM(sendM),
    .recieveM(recieveM), .Master_Data(Master_Data), .M_recieved_Data(M_recieved_Data)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: master and selected slave swap bytes over XB MSB-first shifts.
  logic [7:0] m_sr = 8'h00;
  logic [7:0] smem [1:3];
  logic       pre_en = 1'b0;
  logic [7:0] pre_v [1:3];
  assign M_recieved_Data = m_sr;

  always @(posedge clk) begin
    if (pre_en) begin
      for (int k = 1; k <= 3; k++) smem[k] <= pre_v[k];
    end else if (loadM) begin
      m_sr <= Master_Data;
    end else if (sendM && slave_selection != 2'b00) begin
      m_sr <= {m_sr[6:0], smem[slave_selection][7]};
      smem[slave_selection] <= {smem[slave_selection][6:0], m_sr[7]};
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit m_act = 0, m_err = 0;
  int m_start = 0, m_own = 0, m_ptr = 0;
  logic [1:0] m_sl;
  logic [7:0] m_dat, m_exp, m_rsp = 8'h00;

  int got_cyc, t0, n_load, n_send;
  logic [2:0] got_done;
  logic       got_err;
  logic [7:0] got_rsp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by one clock.
  task automatic cmp_cycle();
    logic [2:0] e_grant, e_done;
    logic       e_err, e_busy, e_load, e_send;
    logic [1:0] e_ss;
    logic [7:0] e_md, e_rsp;
    int d, w;
    cyc++;
    e_grant = 0; e_done = 0; e_err = 0; e_busy = 0; e_load = 0; e_send = 0;
    e_ss = 0; e_md = 0;
    if (!rst) begin
      m_act = 0; m_ptr = 0; m_rsp = 8'h00;
    end
    e_rsp = m_rsp;
    d = cyc - m_start;
    if (m_act) begin
      e_grant = 3'(1 << m_own);
      e_busy  = 1;
      if (m_err) begin
        e_done = e_grant; e_err = 1;
      end else begin
        e_ss = m_sl; e_md = m_dat;
        e_load = (d == 1);
        e_send = (d >= 3 && d <= 2 + XB);
        if (d == 3 + XB) begin e_done = e_grant; e_rsp = m_exp; end
      end
    end
    chk("grant", grant, e_grant);        chk("done", done, e_done);
    chk("err", err, e_err);              chk("busy", busy, e_busy);
    chk("loadM", loadM, e_load);         chk("loadS", loadS, e_load);
    chk("sendM", sendM, e_send);         chk("recieveM", recieveM, e_send);
    chk("slave_selection", slave_selection, e_ss);
    chk("Master_Data", Master_Data, e_md);
    chk("rsp_data", rsp_data, e_rsp);
    if (m_act && !m_err && d == 3 + XB) chk("slave_received", smem[m_sl], m_dat);
    n_load += int'(loadM);
    n_send += int'(sendM);
    if (done != 0 && got_done == 0) begin
      got_done = done; got_cyc = cyc; got_rsp = rsp_data; got_err = err;
    end
    if (!rst) return;
    if (m_act) begin
      if (m_err || d == 3 + XB) begin
        m_act = 0;
        if (!m_err) m_rsp = m_exp;
      end
    end else if (req != 0) begin
      w = -1;
      for (int i = 0; i < 3; i++)
        if (w < 0 && req[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
      m_own = w; m_sl = req_slave[2*w +: 2]; m_dat = req_data[8*w +: 8];
      m_err = (m_sl == 2'b00);
      m_exp = m_err ? 8'h00 : smem[m_sl];
      m_start = cyc; m_act = 1; m_ptr = (w + 1) % 3;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_watch();
    got_done = 0; got_err = 0; got_cyc = -1; got_rsp = 8'h00;
    n_load = 0; n_send = 0; t0 = cyc + 1;
  endtask

  task automatic run_xfer(input int budget, input int drop_at);
    start_watch();
    for (int i = 0; i < budget && got_done == 0; i++) begin
      tick();
      if (drop_at > 0 && n_send == drop_at) req = 3'b000;
    end
    chk("xfer_completed", got_done != 0, 1);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pre_v[1] = a; pre_v[2] = b; pre_v[3] = c; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  logic [2:0] own_q [$];
  logic [7:0] rsp_q [$];
  logic [7:0] keep;

  initial begin
    rst = 1'b0; req = 0; req_slave = 0; req_data = 0;
    pre_v[1] = 0; pre_v[2] = 0; pre_v[3] = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Single transfer to slave 1.
    preload(8'hAA, 8'h00, 8'h00);
    req_slave = 6'b00_00_01; req_data = 24'h0000F0; req = 3'b001;
    run_xfer(20, 0);
    req = 3'b000;
    chk("t1_latency", 32'(got_cyc - t0), 11);
    chk("t1_load_cycles", n_load, 1);
    chk("t1_send_cycles", n_send, 8);
    chk("t1_done_owner", got_done, 3'b001);
    chk("t1_rsp", got_rsp, 8'hAA);
    chk("t1_slave1", smem[1], 8'hF0);
    tick();

    // Round-robin with all three held.
    do_reset();
    preload(8'h83, 8'h83, 8'hCC);
    req_slave = 6'b11_10_01; req_data = 24'hFF8181; req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      run_xfer(20, 0);
      own_q.push_back(got_done); rsp_q.push_back(got_rsp);
    end
    req = 3'b000;
    chk("rr_own0", own_q[0], 3'b001); chk("rr_own1", own_q[1], 3'b010);
    chk("rr_own2", own_q[2], 3'b100); chk("rr_own3", own_q[3], 3'b001);
    chk("rr_rsp0", rsp_q[0], 8'h83);  chk("rr_rsp1", rsp_q[1], 8'h83);
    chk("rr_rsp2", rsp_q[2], 8'hCC);  chk("rr_rsp3", rsp_q[3], 8'h81);
    tick();

    // Illegal slave select.
    keep = rsp_data;
    req_slave = 6'b00_00_00; req = 3'b010;
    run_xfer(5, 0);
    req = 3'b000;
    chk("ill_latency", 32'(got_cyc - t0), 1);
    chk("ill_owner", got_done, 3'b010);
    chk("ill_err", got_err, 1);
    chk("ill_no_load", n_load, 0);
    chk("ill_no_send", n_send, 0);
    chk("ill_rsp_kept", got_rsp, keep);
    tick();

    // Request dropped mid-shift still completes; pointer wraps to 0.
    req_slave = 6'b11_10_01; req_data = 24'h5A1234; req = 3'b100;
    run_xfer(20, 3);
    chk("drop_owner", got_done, 3'b100);
    tick();
    req = 3'b111;
    run_xfer(20, 0);
    req = 3'b000;
    chk("drop_next_owner", got_done, 3'b001);
    tick();

    // Reset at shift count 4.
    req_slave = 6'b00_10_00; req_data = 24'h003C00; req = 3'b010;
    start_watch();
    for (int i = 0; i < 20 && n_send < 4; i++) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);        chk("rst_sendM", sendM, 0);
    chk("rst_grant", grant, 0);      chk("rst_done", done, 0);
    chk("rst_ss", slave_selection, 0); chk("rst_md", Master_Data, 0);
    chk("rst_rsp", rsp_data, 0);
    repeat (2) tick();
    chk("rst_no_done", got_done, 0);
    rst = 1'b1;
    run_xfer(20, 0);
    req = 3'b000;
    chk("rst_after_owner", got_done, 3'b010);
    tick();

    // Randomized traffic with in-flight input churn and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) req_slave = 6'($urandom);
      if ($urandom_range(0, 3) == 0) req_data = 24'($urandom);
      if ($urandom_range(0, 599) == 0) rst = 1'b0;
      else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
      tick();
    end
    rst = 1'b1;
    req = 3'b000;
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
